// File: rtl/pipe_pkg.sv
// Stage-boundary field widths and packed bundles shared by the core's pipeline registers.
// Callers pack/unpack stage payloads by name; pipe_stage_reg itself treats them as opaque bits.
package pipe_pkg;

  localparam int CTRL_W_IDEX  = 13;
  localparam int DATA_W_IDEX  = 111;
  localparam int CTRL_W_EXMEM = 5;
  localparam int DATA_W_EXMEM = 102;
  localparam int CTRL_W_MEMWB = 2;
  localparam int DATA_W_MEMWB = 69;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } skid_state_e;

  typedef struct packed {
    logic       reg_write;
    logic       mem_to_reg;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
    logic       reg_dst;
    logic       alu_src;
    logic [5:0] alu_op;
  } idex_ctrl_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [4:0]  shamt;
    logic [4:0]  rt;
    logic [4:0]  rd;
  } idex_data_t;

  typedef struct packed {
    logic reg_write;
    logic mem_to_reg;
    logic mem_read;
    logic mem_write;
    logic branch;
  } exmem_ctrl_t;

  typedef struct packed {
    logic [31:0] branch_target;
    logic        zero;
    logic [31:0] alu_result;
    logic [31:0] rd2;
    logic [4:0]  dst;
  } exmem_data_t;

  typedef struct packed {
    logic reg_write;
    logic mem_to_reg;
  } memwb_ctrl_t;

  typedef struct packed {
    logic [31:0] read_data;
    logic [31:0] alu_result;
    logic [4:0]  dst;
  } memwb_data_t;

endpackage

// File: rtl/pipe_skid_buf.sv
// Two-entry (main + skid) stage storage, 1-cycle latency; in_ready is registered and drops only
// when the skid slot is occupied, so out_ready never reaches in_ready combinationally.
module pipe_skid_buf
  import pipe_pkg::*;
#(
  parameter int CTRL_W = 13,
  parameter int DATA_W = 111
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data
);

  skid_state_e       r_state;
  logic              r_in_rdy;
  logic              r_out_vld;
  logic [CTRL_W-1:0] r_main_ctrl;
  logic [DATA_W-1:0] r_main_data;
  logic [CTRL_W-1:0] r_skid_ctrl;
  logic [DATA_W-1:0] r_skid_data;
  logic              w_acc;

  assign w_acc = in_valid & r_in_rdy;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_EMPTY;
      r_in_rdy    <= 1'b1;
      r_out_vld   <= 1'b0;
      r_main_ctrl <= '0;
      r_main_data <= '0;
      r_skid_ctrl <= '0;
      r_skid_data <= '0;
    end else if (flush) begin
      r_state     <= ST_EMPTY;
      r_in_rdy    <= 1'b1;
      r_out_vld   <= 1'b0;
      r_skid_ctrl <= '0;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_acc) begin
            r_main_ctrl <= in_ctrl;
            r_main_data <= in_data;
            r_out_vld   <= 1'b1;
            r_state     <= ST_ONE;
          end
        end
        ST_ONE: begin
          if (w_acc && out_ready) begin
            r_main_ctrl <= in_ctrl;
            r_main_data <= in_data;
          end else if (w_acc) begin
            // Downstream stalled: park the new entry behind main and stop accepting.
            r_skid_ctrl <= in_ctrl;
            r_skid_data <= in_data;
            r_in_rdy    <= 1'b0;
            r_state     <= ST_FULL;
          end else if (out_ready) begin
            r_out_vld <= 1'b0;
            r_state   <= ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (out_ready) begin
            r_main_ctrl <= r_skid_ctrl;
            r_main_data <= r_skid_data;
            r_in_rdy    <= 1'b1;
            r_state     <= ST_ONE;
          end
        end
        default: begin
          r_state   <= ST_EMPTY;
          r_in_rdy  <= 1'b1;
          r_out_vld <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_rdy;
  assign out_valid = r_out_vld;
  assign out_ctrl  = r_main_ctrl;
  assign out_data  = r_main_data;

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register, 1-cycle latency when empty; SKID=0 gives combinational in_ready,
// SKID=1 a registered in_ready via a 2-entry skid buffer. Bubbles carry zero control.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int CTRL_W = CTRL_W_IDEX,
  parameter int DATA_W = DATA_W_IDEX,
  parameter int SKID   = 0,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt
);

  logic              w_out_vld;
  logic              w_in_rdy;
  logic [CTRL_W-1:0] w_out_ctrl;
  logic [DATA_W-1:0] w_out_data;
  logic [CNT_W-1:0]  r_stall_cnt;

  generate
    if (SKID == 0) begin : g_single
      logic              r_vld;
      logic [CTRL_W-1:0] r_ctrl;
      logic [DATA_W-1:0] r_data;
      logic              w_acc;

      assign w_in_rdy = ~r_vld | out_ready;
      assign w_acc    = in_valid & w_in_rdy;

      always_ff @(posedge clk) begin
        if (rst) begin
          r_vld  <= 1'b0;
          r_ctrl <= '0;
          r_data <= '0;
        end else if (flush) begin
          r_vld  <= 1'b0;
          r_ctrl <= '0;
        end else if (w_acc) begin
          r_vld  <= 1'b1;
          r_ctrl <= in_ctrl;
          r_data <= in_data;
        end else if (out_ready) begin
          r_vld <= 1'b0;
        end
      end

      assign w_out_vld  = r_vld;
      assign w_out_ctrl = r_ctrl;
      assign w_out_data = r_data;
    end else begin : g_skid
      pipe_skid_buf #(
        .CTRL_W (CTRL_W),
        .DATA_W (DATA_W)
      ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (w_in_rdy),
        .in_ctrl   (in_ctrl),
        .in_data   (in_data),
        .out_valid (w_out_vld),
        .out_ready (out_ready),
        .out_ctrl  (w_out_ctrl),
        .out_data  (w_out_data)
      );
    end
  endgenerate

  // Saturating so long stalls stay visible instead of wrapping to small values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= '0;
    end else if (!flush && w_out_vld && !out_ready && (r_stall_cnt != {CNT_W{1'b1}})) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign in_ready  = w_in_rdy;
  assign out_valid = w_out_vld;
  assign out_ctrl  = w_out_vld ? w_out_ctrl : '0;
  assign out_data  = w_out_data;
  assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench: a = SKID=0, b = SKID=1, c = SKID=0 with a 4-bit stall counter.
module tb_pipe_stage_reg;
  import pipe_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         a_rst, a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [12:0]  a_in_ctrl, a_out_ctrl;
  logic [110:0] a_in_data, a_out_data;
  logic [15:0]  a_stall;
  logic         b_rst, b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [12:0]  b_in_ctrl, b_out_ctrl;
  logic [110:0] b_in_data, b_out_data;
  logic [15:0]  b_stall;
  logic         c_rst, c_flush, c_in_valid, c_in_ready, c_out_valid, c_out_ready;
  logic [12:0]  c_in_ctrl, c_out_ctrl;
  logic [110:0] c_in_data, c_out_data;
  logic [3:0]   c_stall;

  int errors = 0;
  int checks = 0;

  pipe_stage_reg #(.SKID(0)) u_a (
    .clk(clk), .rst(a_rst), .flush(a_flush), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_ctrl(a_in_ctrl), .in_data(a_in_data), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_ctrl(a_out_ctrl), .out_data(a_out_data), .stall_cnt(a_stall));

  pipe_stage_reg #(.SKID(1)) u_b (
    .clk(clk), .rst(b_rst), .flush(b_flush), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_ctrl(b_in_ctrl), .in_data(b_in_data), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_ctrl(b_out_ctrl), .out_data(b_out_data), .stall_cnt(b_stall));

  pipe_stage_reg #(.SKID(0), .CNT_W(4)) u_c (
    .clk(clk), .rst(c_rst), .flush(c_flush), .in_valid(c_in_valid), .in_ready(c_in_ready),
    .in_ctrl(c_in_ctrl), .in_data(c_in_data), .out_valid(c_out_valid), .out_ready(c_out_ready),
    .out_ctrl(c_out_ctrl), .out_data(c_out_data), .stall_cnt(c_stall));

  function automatic logic [110:0] mk_data(input logic [31:0] pc, input logic [31:0] rd1,
                                           input logic [31:0] rd2);
    idex_data_t d;
    d = '0;
    d.pc  = pc;
    d.rd1 = rd1;
    d.rd2 = rd2;
    return d;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    {a_rst, b_rst, c_rst} = 3'b111;
    {a_flush, b_flush, c_flush} = 3'b000;
    {a_in_valid, b_in_valid, c_in_valid} = 3'b000;
    {a_out_ready, b_out_ready, c_out_ready} = 3'b000;
    a_in_ctrl = '0; b_in_ctrl = '0; c_in_ctrl = '0;
    a_in_data = '0; b_in_data = '0; c_in_data = '0;
    step();
    step();
    {a_rst, b_rst, c_rst} = 3'b000;
    #1;
    checks++; if (a_out_valid !== 1'b0 || b_out_valid !== 1'b0 || c_out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_vld got=%b%b%b exp=000", a_out_valid, b_out_valid, c_out_valid); end
    checks++; if (a_out_ctrl !== 13'h0 || b_out_ctrl !== 13'h0 || c_out_ctrl !== 13'h0) begin
      errors++; $display("FAIL reset_ctrl got=%h/%h/%h exp=0", a_out_ctrl, b_out_ctrl, c_out_ctrl); end
    checks++; if (a_out_data !== '0 || b_out_data !== '0) begin
      errors++; $display("FAIL reset_data got=%h/%h exp=0", a_out_data, b_out_data); end
    checks++; if (a_stall !== 16'd0 || b_stall !== 16'd0 || c_stall !== 4'd0) begin
      errors++; $display("FAIL reset_stall got=%0d/%0d/%0d exp=0", a_stall, b_stall, c_stall); end
    checks++; if (a_in_ready !== 1'b1 || b_in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_in_ready got=%b%b exp=11", a_in_ready, b_in_ready); end
  endtask

  task automatic test_single();
    a_out_ready = 1'b1;
    a_in_valid  = 1'b1;
    a_in_ctrl   = 13'h1A5;
    a_in_data   = mk_data(32'h0000_0040, 32'h5, 32'h7);
    #1;
    checks++; if (a_out_ctrl !== 13'h0) begin
      errors++; $display("FAIL single_bubble_ctrl got=%h exp=0", a_out_ctrl); end
    step();
    a_in_valid = 1'b0;
    checks++; if (a_out_valid !== 1'b1 || a_out_ctrl !== 13'h1A5) begin
      errors++; $display("FAIL single_out got=%b/%h exp=1/1a5", a_out_valid, a_out_ctrl); end
    checks++; if (a_out_data !== mk_data(32'h0000_0040, 32'h5, 32'h7)) begin
      errors++; $display("FAIL single_data got=%h", a_out_data); end
    step();
    checks++; if (a_out_valid !== 1'b0 || a_out_ctrl !== 13'h0) begin
      errors++; $display("FAIL single_drain got=%b/%h exp=0/0", a_out_valid, a_out_ctrl); end
  endtask

  task automatic test_back_to_back();
    a_out_ready = 1'b1;
    a_in_valid  = 1'b1;
    a_in_ctrl   = 13'h100;
    a_in_data   = mk_data(32'h100, 32'd0, 32'hFFFF_FFFF);
    for (int k = 0; k < 8; k++) begin
      step();
      checks++; if (a_out_valid !== 1'b1 || a_out_ctrl !== 13'h100 + 13'(k) ||
                    a_out_data !== mk_data(32'h100 + 32'(4 * k), 32'(k), ~32'(k))) begin
        errors++; $display("FAIL b2b_%0d got=%b/%h exp=1/%h", k, a_out_valid, a_out_ctrl, 13'h100 + 13'(k)); end
      if (k < 7) begin
        a_in_ctrl = 13'h100 + 13'(k + 1);
        a_in_data = mk_data(32'h100 + 32'(4 * (k + 1)), 32'(k + 1), ~32'(k + 1));
      end else begin
        a_in_valid = 1'b0;
      end
    end
    step();
    checks++; if (a_out_valid !== 1'b0) begin
      errors++; $display("FAIL b2b_end got=%b exp=0", a_out_valid); end
  endtask

  task automatic test_skid_stall();
    b_out_ready = 1'b0;
    b_in_valid  = 1'b1;
    b_in_ctrl   = 13'h0AA;
    b_in_data   = mk_data(32'hA, 32'h1, 32'h2);
    step();
    checks++; if (b_out_valid !== 1'b1 || b_out_ctrl !== 13'h0AA || b_in_ready !== 1'b1) begin
      errors++; $display("FAIL skid_A got=%b/%h/%b exp=1/0aa/1", b_out_valid, b_out_ctrl, b_in_ready); end
    b_in_ctrl = 13'h0BB;
    b_in_data = mk_data(32'hB, 32'h3, 32'h4);
    step();
    checks++; if (b_in_ready !== 1'b0 || b_out_ctrl !== 13'h0AA) begin
      errors++; $display("FAIL skid_full got=%b/%h exp=0/0aa", b_in_ready, b_out_ctrl); end
    b_in_ctrl = 13'h0CC;
    b_in_data = mk_data(32'hC, 32'h5, 32'h6);
    for (int i = 0; i < 4; i++) step();
    checks++; if (b_stall !== 16'd5 || b_in_ready !== 1'b0 || b_out_ctrl !== 13'h0AA) begin
      errors++; $display("FAIL skid_hold got=%0d/%b/%h exp=5/0/0aa", b_stall, b_in_ready, b_out_ctrl); end
    b_out_ready = 1'b1;
    step();
    checks++; if (b_out_ctrl !== 13'h0BB || b_out_data !== mk_data(32'hB, 32'h3, 32'h4) || b_in_ready !== 1'b1) begin
      errors++; $display("FAIL skid_B got=%h/%b exp=0bb/1", b_out_ctrl, b_in_ready); end
    step();
    b_in_valid = 1'b0;
    checks++; if (b_out_valid !== 1'b1 || b_out_ctrl !== 13'h0CC) begin
      errors++; $display("FAIL skid_C got=%b/%h exp=1/0cc", b_out_valid, b_out_ctrl); end
    step();
    checks++; if (b_out_valid !== 1'b0 || b_stall !== 16'd5) begin
      errors++; $display("FAIL skid_drain got=%b/%0d exp=0/5", b_out_valid, b_stall); end
  endtask

  task automatic test_flush();
    b_out_ready = 1'b0;
    b_in_valid  = 1'b1;
    b_in_ctrl   = 13'h011;
    step();
    b_in_ctrl = 13'h022;
    step();
    b_in_ctrl = 13'h0DD;
    b_flush   = 1'b1;
    step();
    b_flush    = 1'b0;
    b_in_valid = 1'b0;
    checks++; if (b_out_valid !== 1'b0 || b_out_ctrl !== 13'h0 || b_in_ready !== 1'b1) begin
      errors++; $display("FAIL flush_skid got=%b/%h/%b exp=0/0/1", b_out_valid, b_out_ctrl, b_in_ready); end
    checks++; if (b_stall !== 16'd6) begin
      errors++; $display("FAIL flush_stall got=%0d exp=6", b_stall); end
    b_out_ready = 1'b1;
    step();
    step();
    checks++; if (b_out_valid !== 1'b0 || b_out_ctrl !== 13'h0) begin
      errors++; $display("FAIL flush_no_D got=%b/%h exp=0/0", b_out_valid, b_out_ctrl); end
    a_out_ready = 1'b1;
    a_in_valid  = 1'b1;
    a_in_ctrl   = 13'h1FFF;
    a_flush     = 1'b1;
    step();
    a_flush    = 1'b0;
    a_in_valid = 1'b0;
    checks++; if (a_out_valid !== 1'b0 || a_out_ctrl !== 13'h0) begin
      errors++; $display("FAIL flush_single got=%b/%h exp=0/0", a_out_valid, a_out_ctrl); end
  endtask

  task automatic test_rst_flush();
    a_out_ready = 1'b0;
    a_in_valid  = 1'b1;
    a_in_ctrl   = 13'h155;
    a_in_data   = mk_data(32'h80, 32'h9, 32'hA);
    step();
    a_in_ctrl = 13'h0F0;
    step();
    step();
    checks++; if (a_stall !== 16'd2 || a_out_ctrl !== 13'h155) begin
      errors++; $display("FAIL rstfl_pre got=%0d/%h exp=2/155", a_stall, a_out_ctrl); end
    a_rst   = 1'b1;
    a_flush = 1'b1;
    step();
    a_rst      = 1'b0;
    a_flush    = 1'b0;
    a_in_valid = 1'b0;
    #1;
    checks++; if (a_out_valid !== 1'b0 || a_out_ctrl !== 13'h0 || a_out_data !== '0 ||
                  a_stall !== 16'd0 || a_in_ready !== 1'b1) begin
      errors++; $display("FAIL rstfl got=%b/%h/%0d/%b exp=0/0/0/1", a_out_valid, a_out_ctrl, a_stall, a_in_ready); end
  endtask

  task automatic test_saturate();
    c_out_ready = 1'b0;
    c_in_valid  = 1'b1;
    c_in_ctrl   = 13'h077;
    step();
    c_in_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (i == 13) begin
        checks++; if (c_stall !== 4'd14) begin
          errors++; $display("FAIL sat_mid got=%0d exp=14", c_stall); end
      end
    end
    checks++; if (c_stall !== 4'd15 || c_out_valid !== 1'b1) begin
      errors++; $display("FAIL sat_end got=%0d/%b exp=15/1", c_stall, c_out_valid); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_skid_stall();
    test_flush();
    test_rst_flush();
    test_saturate();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Parametrised pipeline-stage register, the generalised replacement for the fixed per-stage latches (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Carries a control field and a data field with a valid/ready handshake, synchronous flush for branch/hazard squash, and an optional 2-entry skid buffer for full throughput under registered backpressure.
- Counts stall cycles for performance visibility.
- Instantiated once per stage boundary in the pipelined core.

Parameters:
- CTRL_W, 13, width of control field (e.g. RegWrite, MemtoReg, MemRead, MemWrite, Branch, RegDst, ALUSrc, ALUOp[5:0]).
- DATA_W, 111, width of data field (e.g. PC, RD1, RD2, extend_immed, rt, rd).
- SKID, 0, 0 = single register with combinational in_ready; 1 = 2-entry skid buffer with registered in_ready.
- CNT_W, 16, width of the saturating stall counter.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  squash all held entries; drop the input offered this cycle.
- in_valid  in  1  upstream entry valid.
- in_ready  out  1  stage can accept this cycle.
- in_ctrl  in  CTRL_W  upstream control field.
- in_data  in  DATA_W  upstream data field.
- out_valid  out  1  held entry valid.
- out_ready  in  1  downstream accepts this cycle.
- out_ctrl  out  CTRL_W  control field, forced 0 when out_valid=0.
- out_data  out  DATA_W  data field.
- stall_cnt  out  CNT_W  saturating count of cycles with out_valid & !out_ready.

Behaviour:
- Interface: reset rst, synchronous, active-high; clock clk.
- Reset: out_valid=0, out_ctrl=0, out_data=0 (every field, including immediate and register indices), skid entry empty and zeroed, stall_cnt=0. in_ready=1 in the cycle after reset.
- rst has priority over flush, which has priority over all handshake activity.
- Transfer in: in_valid & in_ready at a rising edge. Transfer out: out_valid & out_ready at a rising edge.
- Latency: one cycle from accepted input to out_valid=1 when the stage is empty.
- Bubble rule: out_ctrl is gated to 0 whenever out_valid=0, so a bubble never writes registers or memory.
- SKID=0 (single register):
  - in_ready = !out_valid | out_ready (combinational).
  - On accept: main <= input, out_valid <= 1.
  - On transfer out with no accept: out_valid <= 0.
  - Simultaneous in and out: main is replaced, out_valid stays 1.
- SKID=1 (skid buffer): states EMPTY (main empty), ONE (main full), FULL (main + skid full).
  - in_ready = !skid_valid, registered, so no combinational path from out_ready.
  - EMPTY + accept -> ONE.
  - ONE + accept & out_ready -> ONE, main replaced.
  - ONE + accept & !out_ready -> FULL, input goes to skid.
  - ONE + out_ready & no accept -> EMPTY.
  - FULL + out_ready -> ONE, main <= skid. No accept is possible in FULL.
  - Order is strictly FIFO; no entry is dropped or duplicated.
- Flush (either mode):
  - Next cycle out_valid=0, out_ctrl=0, skid empty, state EMPTY.
  - The input offered in the flush cycle is discarded even if in_ready=1.
  - out_data contents are don't-care after flush, but the bench checks that out_ctrl=0.
  - stall_cnt is not cleared by flush.
- stall_cnt: increments every cycle out_valid & !out_ready (and no flush); saturates at 2^CNT_W-1 with no wrap.
- Widths: ctrl and data are opaque bit vectors; the module does no arithmetic on them.

Decomposition:
- Shared package pipe_pkg holds:
  - Field-width constants: CTRL_W_IDEX, DATA_W_IDEX, and the equivalents for other stages.
  - Packed struct typedefs for each stage's control bundle and data bundle, so callers pack/unpack by name.
- One natural sub-module: pipe_skid_buf, the 2-entry storage plus its state machine. It is instantiated only when SKID=1; SKID=0 uses an inline register.

Test Plan:
- Reset, then accept one entry (ctrl=13'h1A5, data=PC 0x00000040 / RD1 0x5 / RD2 0x7, out_ready=1) -> out_valid=1 and values match one cycle later; out_ctrl=0 in all other cycles.
- SKID=0 back-to-back stream of 8 entries with out_ready=1 -> 8 outputs on 8 consecutive cycles, in order.
- SKID=1, hold out_ready=0 for 5 cycles while offering entries A, B, C -> A in main, B in skid, in_ready=0 from cycle 2, C held upstream; release -> A, B, C emitted in order; stall_cnt=5.
- Flush with state FULL and in_valid=1 (entry D) -> next cycle out_valid=0, out_ctrl=0, in_ready=1; D never appears at the output.
- rst and flush asserted together mid-stream -> all outputs and stall_cnt are 0 the next cycle.
- CNT_W=4, hold out_valid=1 and out_ready=0 for 20 cycles -> stall_cnt saturates at 15 and does not wrap.
